// File: rtl/yoda_pkg.sv
// ---------------------------------------------------------------------------
// yoda_pkg
// Shared definitions for the filter datapath output stage.
//   - tx_seq_state_t : state encoding of result_tx_sequencer (3-bit)
//   - ADDR_W_DEF     : default memory address / length width
//   - DATA_W_DEF     : default memory word / UART byte width
//   - GAP_W          : width of the inter-byte gap counter
//   - CLKS_PER_BIT   : UART bit period in clk cycles (used by benches)
// ---------------------------------------------------------------------------
package yoda_pkg;

   localparam int ADDR_W_DEF   = 8;
   localparam int DATA_W_DEF   = 8;
   localparam int GAP_W        = 16;
   localparam int CLKS_PER_BIT = 87;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READ      = 3'd1,
      S_CAPTURE   = 3'd2,
      S_SEND      = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_GAP       = 3'd5,
      S_FINISH    = 3'd6
   } tx_seq_state_t;

endpackage

// File: rtl/result_tx_sequencer.sv
// ---------------------------------------------------------------------------
// result_tx_sequencer
// Reads `len` bytes from the result RAM starting at `base_addr` and hands
// them one at a time to UART_TX, then pulses `done` for one cycle.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle transfer request (accepted only when idle)
//   base_addr  in   first RAM address to send
//   len        in   number of bytes to send (0 = immediate done)
//   mem_rd_en  out  RAM read strobe, data returns the next cycle
//   mem_addr   out  RAM read address
//   mem_rdata  in   RAM read data (1-cycle latency)
//   tx_dv      out  one-cycle data-valid pulse to UART_TX
//   tx_byte    out  byte for UART_TX, stable from tx_dv until tx_done
//   tx_done    in   UART_TX byte-complete pulse
//   busy       out  transfer in progress
//   done       out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module result_tx_sequencer
   import yoda_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] len,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              tx_dv,
   output logic [DATA_W-1:0] tx_byte,
   input  logic              tx_done,
   output logic              busy,
   output logic              done
);

   localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   tx_seq_state_t     state_q,     state_d;
   logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
   logic [ADDR_W-1:0] remaining_q, remaining_d;
   logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
   logic [DATA_W-1:0] tx_byte_q,   tx_byte_d;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         gap_cnt_q   <= '0;
         tx_byte_q   <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         gap_cnt_q   <= gap_cnt_d;
         tx_byte_q   <= tx_byte_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode. Strobes are decoded straight from the
   // state register so an asynchronous reset removes them at once.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      gap_cnt_d   = gap_cnt_q;
      tx_byte_d   = tx_byte_q;
      mem_rd_en   = 1'b0;
      tx_dv       = 1'b0;
      done        = 1'b0;
      busy        = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (len != '0) begin
                  cur_addr_d  = base_addr;
                  remaining_d = len;
                  state_d     = S_READ;
               end else begin
                  // Empty transfer: report completion without touching
                  // memory or the UART.
                  state_d = S_FINISH;
               end
            end
         end

         S_READ: begin
            mem_rd_en = 1'b1;
            state_d   = S_CAPTURE;
         end

         S_CAPTURE: begin
            tx_byte_d = mem_rdata;
            state_d   = S_SEND;
         end

         S_SEND: begin
            tx_dv   = 1'b1;
            state_d = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (tx_done) begin
               cur_addr_d  = cur_addr_q + ONE;   // wraps modulo 2^ADDR_W
               remaining_d = remaining_q - ONE;
               if (remaining_q == ONE) begin
                  state_d = S_FINISH;
               end else if (GAP_CYCLES == 0) begin
                  state_d = S_READ;
               end else begin
                  gap_cnt_d = GAP_LOAD;
                  state_d   = S_GAP;
               end
            end
         end

         S_GAP: begin
            // Loaded with GAP_CYCLES, so exactly GAP_CYCLES cycles are
            // spent here before the next read.
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
            if (gap_cnt_q <= GAP_W'(1)) begin
               state_d = S_READ;
            end
         end

         S_FINISH: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_addr = cur_addr_q;
   assign tx_byte  = tx_byte_q;

endmodule

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
- Downstream stage of the filter datapath. On a transmit_result request it reads `len` bytes from the result RAM, starting at `base_addr`.
- Each byte is handed to UART_TX using its data_valid/tx_done handshake, strictly one byte at a time.
- Ends the transfer with a one-cycle done pulse.
- Sits between the shared data memory and UART_TX inside top_level; it is the source of process_done.

Parameters:
- ADDR_W, 8, memory address width and length width.
- DATA_W, 8, memory word and UART byte width.
- GAP_CYCLES, 0, idle clk cycles inserted after each tx_done before the next memory read (0..2^16-1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request, equivalent to transmit_result
- base_addr  in  ADDR_W  first address to send, equivalent to dest
- len  in  ADDR_W  number of bytes to send
- mem_rd_en  out  1  RAM read strobe; data is valid the next cycle
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- tx_dv  out  1  one-cycle data-valid pulse to UART_TX
- tx_byte  out  DATA_W  byte presented to UART_TX; held stable from tx_dv until tx_done
- tx_done  in  1  UART_TX byte-complete pulse
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high): the following outputs are 0: mem_rd_en, mem_addr, tx_dv, tx_byte, busy, done. Also cur_addr=0, remaining=0, gap_cnt=0, state=IDLE.
- Reset asserted mid-transfer: tx_dv drops immediately and the block returns to IDLE. UART_TX is not re-notified.
- States: IDLE, READ, CAPTURE, SEND, WAIT_DONE, GAP, FINISH.
- IDLE:
  - On start=1 with len!=0: latch cur_addr=base_addr and remaining=len; go to READ.
  - On start=1 with len=0: go to FINISH; no memory or UART activity.
- READ: mem_rd_en=1, mem_addr=cur_addr for exactly one cycle; go to CAPTURE.
- CAPTURE: register tx_byte<=mem_rdata; go to SEND.
- SEND: tx_dv=1 for exactly one cycle; go to WAIT_DONE.
- WAIT_DONE: hold until tx_done=1. Then:
  - cur_addr<=cur_addr+1, modulo 2^ADDR_W (wrap 255->0 at default).
  - remaining<=remaining-1.
  - If remaining==1, go to FINISH.
  - Otherwise, if GAP_CYCLES==0 go to READ; else load gap_cnt=GAP_CYCLES and go to GAP.
- GAP: decrement gap_cnt; when it reaches 1, go to READ.
- FINISH: done=1 for one cycle, busy=0; go to IDLE.
- Latency:
  - start to first tx_dv: 3 cycles (READ, CAPTURE, SEND).
  - tx_done to next tx_dv: 3+GAP_CYCLES cycles.
  - Final tx_done to done: 1 cycle.
- start is ignored in every state except IDLE. base_addr and len are sampled only on acceptance, so later changes have no effect on the transfer in progress.
- tx_done is ignored outside WAIT_DONE; a stray pulse causes no state change.
- Only one byte is ever in flight, so tx_dv is never reasserted before tx_done.
- Arithmetic: remaining is unsigned ADDR_W; len=2^ADDR_W-1 (255) sends 255 bytes. There is no 256-byte case.

Decomposition:
- Shared package yoda_pkg holds:
  - the state enum typedef (tx_seq_state_t, 3-bit);
  - the ADDR_W/DATA_W defaults;
  - UART bit-period constant CLKS_PER_BIT, used by benches.
- No sub-module; the gap counter is inline. This is a single module of roughly 150-200 lines.

Test Plan:
- Basic transfer:
  - Stimulus: RAM[150..152]={0x11,0x22,0x33}; start with base=150, len=3; behavioural UART_TX model returns tx_done 10 cycles after tx_dv.
  - Required response: tx_byte sequence 0x11, 0x22, 0x33; first tx_dv 3 cycles after start; done pulses once, 1 cycle after the third tx_done; busy drops that same cycle.
- Zero length:
  - Stimulus: start with len=0.
  - Required response: done 1 cycle later; mem_rd_en and tx_dv never assert.
- Address wrap:
  - Stimulus: base=254, len=4.
  - Required response: mem_addr sequence 254, 255, 0, 1.
- Start while busy:
  - Stimulus: second start pulse, with different base/len, during WAIT_DONE of byte 2 of a 5-byte transfer.
  - Required response: ignored; exactly 5 bytes sent from the original base; single done pulse.
- Reset mid-transfer:
  - Stimulus: assert rst during WAIT_DONE of byte 2, asynchronously (not aligned to clk).
  - Required response: tx_dv, busy and done are 0 immediately; after release, a new start (base=10, len=2) sends RAM[10], RAM[11] correctly.
- Gap and stray done:
  - Stimulus: GAP_CYCLES=4; inject a tx_done pulse while in IDLE; then a 2-byte transfer.
  - Required response: no reaction to the stray tx_done; exactly 7 cycles from the first tx_done to the second tx_dv.
